// File: rtl/axi_lite_arbiter.sv
// Arbitrates NREQ simple-handshake requesters onto one AXI4-Lite master port, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority (lowest index).
module axi_lite_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter logic [2:0]  PROT = 3'b000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [32*NREQ-1:0]   addr,
  input  logic [32*NREQ-1:0]   wdata,
  input  logic [4*NREQ-1:0]    wstrb,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rdata,
  output logic [1:0]           resp,
  output logic [31:0]          axi_araddr,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,
  output logic [2:0]           axi_arprot,
  input  logic [31:0]          axi_rdata,
  input  logic [1:0]           axi_rresp,
  input  logic                 axi_rvalid,
  output logic                 axi_rready,
  output logic [31:0]          axi_awaddr,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [2:0]           axi_awprot,
  output logic [31:0]          axi_wdata,
  output logic [3:0]           axi_wstrb,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic [1:0]           axi_bresp,
  input  logic                 axi_bvalid,
  output logic                 axi_bready
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t          state;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   win;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_wstrb;
  logic            sel_we;
  logic            aw_ok;
  logic            w_ok;

  assign axi_arprot = PROT;
  assign axi_awprot = PROT;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
  logic [IW-1:0] hi_win;
  logic [IW-1:0] lo_win;
  logic          hi_found;
  logic          lo_found;

  // First requester above the pointer wins; otherwise wrap to the lowest pending index.
  always_comb begin
    hi_win   = '0;
    lo_win   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i] && (i > 32'(ptr)) && !hi_found) begin
        hi_win   = IW'(i);
        hi_found = 1'b1;
      end
      if (req[i] && !lo_found) begin
        lo_win   = IW'(i);
        lo_found = 1'b1;
      end
    end
    win = hi_found ? hi_win : lo_win;
  end
`else
  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i] && !found) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == win) begin
        sel_addr  = addr[32*i +: 32];
        sel_wdata = wdata[32*i +: 32];
        sel_wstrb = wstrb[4*i +: 4];
        sel_we    = we[i];
      end
    end
  end

  // A channel counts as accepted once its valid has dropped or is being taken this cycle.
  assign aw_ok = !axi_awvalid || axi_awready;
  assign w_ok  = !axi_wvalid  || axi_wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      resp        <= '0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr         <= IW'(NREQ - 1);
`endif
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt <= win;
`ifdef ARB_ROUND_ROBIN_EN
            ptr <= win;
`endif
            if (sel_we) begin
              axi_awaddr  <= sel_addr;
              axi_wdata   <= sel_wdata;
              axi_wstrb   <= sel_wstrb;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= WADDR;
            end else begin
              axi_araddr  <= sel_addr;
              axi_arvalid <= 1'b1;
              state       <= RADDR;
            end
          end
        end
        RADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RDATA;
          end
        end
        RDATA: begin
          if (axi_rvalid) begin
            rdata      <= axi_rdata;
            resp       <= axi_rresp;
            axi_rready <= 1'b0;
            done[gnt]  <= 1'b1;
            state      <= IDLE;
          end
        end
        WADDR: begin
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            axi_bready <= 1'b1;
            state      <= WRESP;
          end
        end
        WRESP: begin
          if (axi_bvalid) begin
            resp       <= axi_bresp;
            axi_bready <= 1'b0;
            done[gnt]  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Shares the core's single AXI4-Lite master bus (MMU/data port) between NREQ simple-handshake requesters (e.g. load/store unit, loader, debug). One transaction at a time: selects a requester, runs the AXI read or write handshake to completion, and returns data/response with a one-cycle done pulse. Sits between the requesters inside `core` and the `axi_*` ports on the core boundary.

## Interface
- NREQ, 2, number of requesters (2..8)
- PROT, 3'b000, constant driven on axi_arprot/axi_awprot
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- req  in  NREQ  request i pending; held high until done[i]
- we  in  NREQ  1 = write, 0 = read
- addr  in  32*NREQ  requester i at [32i+31:32i]
- wdata  in  32*NREQ  write data, same packing
- wstrb  in  4*NREQ  byte strobes, same packing
- done  out  NREQ  one-cycle completion pulse to granted requester
- rdata  out  32  read data, valid with done, held until next done
- resp  out  2  rresp/bresp of the completed transaction, valid with done
- axi_araddr  out  32  read address
- axi_arvalid  out  1  read address valid
- axi_arready  in  1  read address ready
- axi_arprot  out  3  = PROT
- axi_rdata  in  32  read data
- axi_rresp  in  2  read response
- axi_rvalid  in  1  read data valid
- axi_rready  out  1  read data ready
- axi_awaddr  out  32  write address
- axi_awvalid  out  1  write address valid
- axi_awready  in  1  write address ready
- axi_awprot  out  3  = PROT
- axi_wdata  out  32  write data
- axi_wstrb  out  4  write strobes
- axi_wvalid  out  1  write data valid
- axi_wready  in  1  write data ready
- axi_bresp  in  2  write response
- axi_bvalid  in  1  write response valid
- axi_bready  out  1  write response ready

## Operation
- States: IDLE, RADDR, RDATA, WADDR, WRESP. All outputs registered.
- IDLE: if any req, pick winner g (see Configuration), latch addr/wdata/wstrb/we of g; read -> RADDR with arvalid=1; write -> WADDR with awvalid=wvalid=1.
- RADDR: hold arvalid/araddr until arready; then arvalid=0, rready=1, -> RDATA. RDATA: on rvalid capture rdata/rresp, rready=0, done[g]=1, -> IDLE.
- WADDR: awvalid and wvalid drop independently on their own handshake (either order, or same cycle); once both accepted, bready=1 -> WRESP. WRESP: on bvalid capture bresp, bready=0, done[g]=1, -> IDLE.
- req/we/addr of non-granted or granted requesters ignored after latching; requester drops req in the cycle done is seen, else it is re-arbitrated as a new request.
- rdata unchanged on write completions.

## Timing
- Reset: state IDLE; all axi_*valid, rready, bready = 0; axi addr/data/strb = 0; done = 0; rdata = 0; resp = 0; round-robin pointer = NREQ-1.
- Read, zero-wait slave: req at t -> arvalid t+1; arready t+1 -> rready t+2; rvalid t+2 -> done t+3. Write: awvalid/wvalid t+1, bready t+2, done t+3.
- Back-to-back: IDLE always spends one cycle; next grant issues valid one cycle after done.
- rstn low mid-transaction: immediate return to reset values; in-flight AXI transaction abandoned (slave shares rstn).

## Configuration
- ARB_ROUND_ROBIN_EN defined: winner is first req at index pointer+1, pointer+2, ... mod NREQ; pointer updated to g on grant. Undefined: fixed priority, lowest index wins; pointer unused.

## Test plan
- Single read req[0], addr 0x0000_1000, slave returns 0xDEADBEEF rresp 0 with zero wait -> done[0] at t+3, rdata 0xDEADBEEF, resp 0.
- Write req[1] addr 0x40, wdata 0x1234_5678, wstrb 4'b0011; wready 3 cycles before awready -> awaddr/wdata match, bready only after both, done[1], resp = bresp.
- req = 2'b11 held continuously, round robin -> grants 0,1,0,1; without macro -> 0,0,0.
- Slave rresp 2'b10 after 5-cycle rvalid stall -> arvalid deasserted after arready, rready held 5 cycles, resp 2'b10.
- rstn low during WRESP -> outputs at reset values same cycle, next req after reset granted cleanly (requester 0 wins first).
